// File: rtl/lfsr_param.sv
// Parameterised Fibonacci/Galois LFSR with seed load, lockup recovery,
// step counting and period detection against the active seed.
module lfsr_param #(
  parameter int unsigned      WIDTH  = 7,
  parameter logic [WIDTH-1:0] TAPS   = 7'b1000100,
  parameter bit               GALOIS = 1'b0,
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] step_count,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup_err
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q,  seed_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] len_q,   len_d;
  logic             done_q,  done_d;
  logic             lock_q,  lock_d;

  logic [WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0] cnt_inc;

  always_comb begin
    if (GALOIS) begin
      step_nxt = {state_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_q[WIDTH-1]}} & TAPS);
    end else begin
      step_nxt = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // Load outranks en; an all-zero seed would lock the register, so fall back to SEED.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    lock_d  = 1'b0;
    if (load) begin
      cnt_d = '0;
      if (seed_in == '0) begin
        state_d = SEED;
        seed_d  = SEED;
        lock_d  = 1'b1;
      end else begin
        state_d = seed_in;
        seed_d  = seed_in;
      end
    end else if (en) begin
      state_d = step_nxt;
      if (step_nxt == seed_q) begin
        done_d = 1'b1;
        len_d  = cnt_inc;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
      seed_q  <= SEED;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      lock_q  <= lock_d;
    end
  end

  assign data_out    = state_q;
  assign step_count  = cnt_q;
  assign period_len  = len_q;
  assign period_done = done_q;
  assign lockup_err  = lock_q;

endmodule

// File: tb/tb_lfsr_param.sv
// Scoreboard bench: a Fibonacci (default) and a Galois instance share stimulus;
// an arithmetic reference model queues expectations, a monitor pops and compares.
module tb_lfsr_param;

  localparam int unsigned TAPS_F = 7'h44;
  localparam int unsigned TAPS_G = 7'h09;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [6:0] seed_in;

  logic [6:0] data0, cnt0, len0, data1, cnt1, len1;
  logic       done0, lock0, done1, lock1;

  lfsr_param dut_fib (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .data_out(data0), .step_count(cnt0), .period_done(done0),
    .period_len(len0), .lockup_err(lock0)
  );

  lfsr_param #(.WIDTH(7), .TAPS(7'b0001001), .GALOIS(1'b1), .SEED(7'd1)) dut_gal (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .data_out(data1), .step_count(cnt1), .period_done(done1),
    .period_len(len1), .lockup_err(lock1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned data, cnt, len;
    bit          done, lock;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int unsigned m_state[2], m_seed[2], m_cnt[2], m_len[2];
  bit          m_done[2], m_lock[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Next state from the polynomial rules using plain integer arithmetic.
  function automatic int unsigned ref_next(input int unsigned g, input int unsigned s,
                                           input int unsigned taps);
    int unsigned v;
    v = (s * 2) % 128;
    if (g == 0) v = v + ($countones(s & taps) % 2);
    else if (s >= 64) v = v ^ taps;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 1; m_seed[k] = 1; m_cnt[k] = 0; m_len[k] = 0;
      m_done[k] = 0;  m_lock[k] = 0;
    end
  endtask

  task automatic model_apply(input bit e, input bit l, input int unsigned s);
    exp_t x;
    int unsigned nx;
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      m_lock[k] = 0;
      if (l) begin
        m_cnt[k] = 0;
        if (s == 0) begin
          m_state[k] = 1; m_seed[k] = 1; m_lock[k] = 1;
        end else begin
          m_state[k] = s; m_seed[k] = s;
        end
      end else if (e) begin
        nx = ref_next(k, m_state[k], (k == 0) ? TAPS_F : TAPS_G);
        if (nx == m_seed[k]) begin
          m_done[k] = 1;
          m_len[k]  = (m_cnt[k] + 1) % 128;
          m_cnt[k]  = 0;
        end else begin
          m_cnt[k] = (m_cnt[k] + 1) % 128;
        end
        m_state[k] = nx;
      end
      x.data = m_state[k]; x.cnt = m_cnt[k]; x.len = m_len[k];
      x.done = m_done[k];  x.lock = m_lock[k];
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
  endtask

  task automatic step(input bit e, input bit l, input logic [6:0] s);
    @(negedge clk);
    en = e; load = l; seed_in = s;
    model_apply(e, l, s);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fib_data"}, data0, 1);  chk({tag, "_gal_data"}, data1, 1);
    chk({tag, "_fib_cnt"},  cnt0, 0);   chk({tag, "_gal_cnt"},  cnt1, 0);
    chk({tag, "_fib_len"},  len0, 0);   chk({tag, "_gal_len"},  len1, 0);
    chk({tag, "_fib_done"}, done0, 0);  chk({tag, "_fib_lock"}, lock0, 0);
  endtask

  // Monitor: every clock presents an output; compare against queued expectation.
  initial begin
    exp_t e0, e1;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("sb_fib_data", data0, e0.data); chk("sb_fib_cnt", cnt0, e0.cnt);
        chk("sb_fib_len", len0, e0.len);    chk("sb_fib_done", done0, e0.done);
        chk("sb_fib_lock", lock0, e0.lock);
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("sb_gal_data", data1, e1.data); chk("sb_gal_cnt", cnt1, e1.cnt);
        chk("sb_gal_len", len1, e1.len);    chk("sb_gal_done", done1, e1.done);
        chk("sb_gal_lock", lock1, e1.lock);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned gal_seq[7];
    int unsigned r;
    gal_seq = '{2, 4, 8, 16, 32, 64, 9};
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    // Full period from reset: known start sequence, no early return, one pulse.
    for (int i = 1; i <= 127; i++) begin
      step(1'b1, 1'b0, 7'd0);
      if (i == 1) chk("fib_seq1", data0, 2);
      if (i == 2) chk("fib_seq2", data0, 4);
      if (i == 3) chk("fib_seq3", data0, 9);
      if (i <= 7) chk("gal_seq", data1, gal_seq[i-1]);
      if (i < 127) chk("fib_no_early_repeat", (data0 == 7'd1), 0);
    end
    chk("fib_period_data", data0, 1);
    chk("fib_period_done", done0, 1);
    chk("fib_period_len", len0, 127);
    chk("fib_period_cnt", cnt0, 0);
    step(1'b0, 1'b0, 7'd0);
    chk("fib_done_one_cycle", done0, 0);
    chk("fib_len_held", len0, 127);

    // Zero-seed load with en high: recovers to SEED without stepping.
    repeat (5) step(1'b1, 1'b0, 7'd0);
    step(1'b1, 1'b1, 7'd0);
    chk("lock_data", data0, 1);
    chk("lock_pulse", lock0, 1);
    chk("lock_cnt", cnt0, 0);
    step(1'b0, 1'b0, 7'd0);
    chk("lock_one_cycle", lock0, 0);

    // Seed 0x55 then a full period back to it.
    step(1'b0, 1'b1, 7'h55);
    chk("load55_data", data0, 7'h55);
    chk("load55_noflags", {done0, lock0}, 0);
    repeat (127) step(1'b1, 1'b0, 7'd0);
    chk("p55_data", data0, 7'h55);
    chk("p55_done", done0, 1);
    chk("p55_len", len0, 127);

    // Idle cycles hold everything.
    repeat (3) step(1'b0, 1'b0, 7'h12);
    repeat (10) step(1'b1, 1'b0, 7'd0);

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_vals("async");
    #1 rst = 1'b0;
    model_reset();

    // Reset held across a load edge aborts the load.
    repeat (4) step(1'b1, 1'b0, 7'd0);
    @(negedge clk);
    en = 1'b1; load = 1'b1; seed_in = 7'h33; rst = 1'b1;
    @(posedge clk);
    #1 chk_reset_vals("rst_load");
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 7'd0);
    chk("post_rst_first_step", data0, 2);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       step($urandom_range(0, 1), 1'b1, 7'd0);
      else if (r < 10) step($urandom_range(0, 1), 1'b1, 7'($urandom_range(0, 127)));
      else if (r < 30) step(1'b0, 1'b0, 7'($urandom));
      else             step(1'b1, 1'b0, 7'($urandom));
    end

    step(1'b0, 1'b0, 7'd0);
    @(posedge clk);
    #3;
    chk("sb_drained", q0.size() + q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_param.md
LFSR_PARAM -- requirements
Module: lfsr_param

Interface
REQ-001 Parameter WIDTH, default 7, register width; legal range 3..32.
REQ-002 Parameter TAPS, default 7'b1000100 (WIDTH bits), feedback tap mask; must be nonzero.
REQ-003 Parameter GALOIS, default 0; 0 selects Fibonacci form, 1 selects Galois form.
REQ-004 Parameter SEED, default 1, reset and lockup-recovery value; must be nonzero.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  one clock; reset is asynchronous and active-high.
REQ-007 en  in  1  advance one LFSR step this cycle.
REQ-008 load  in  1  load seed_in this cycle.
REQ-009 seed_in  in  WIDTH  seed value used when load=1.
REQ-010 data_out  out  WIDTH  current LFSR state.
REQ-011 step_count  out  WIDTH  enabled steps since the last reset, load or period completion.
REQ-012 period_done  out  1  one-cycle pulse when the state returns to the active seed.
REQ-013 period_len  out  WIDTH  length of the most recently completed period.
REQ-014 lockup_err  out  1  one-cycle pulse when an all-zero seed was rejected.

Function
REQ-015 The block SHALL hold an active-seed register, loaded with SEED on reset and with the accepted seed on load.
REQ-016 Priority each edge SHALL be rst > load > en; en is ignored in a load cycle.
REQ-017 Fibonacci step: state <= {state[WIDTH-2:0], ^(state & TAPS)}.
REQ-018 Galois step: state <= {state[WIDTH-2:0], 1'b0} ^ ({WIDTH{state[WIDTH-1]}} & TAPS).
REQ-019 en=0 and load=0 SHALL hold state, step_count and period_len unchanged.
REQ-020 Load with nonzero seed_in: state and active seed <= seed_in, step_count <= 0, no flag pulses, next cycle.
REQ-021 Load with seed_in==0: state and active seed <= SEED, step_count <= 0, lockup_err pulses 1 the following cycle.
REQ-022 Each enabled step SHALL increment step_count modulo 2^WIDTH, wrapping silently.
REQ-023 If the next state of an enabled step equals the active seed: period_done pulses 1 next cycle, period_len <= step_count+1 (truncated to WIDTH), step_count <= 0.
REQ-024 period_done and lockup_err SHALL be registered and high for exactly one cycle per event.
REQ-025 All-zero state is unreachable in normal operation; no other zero-state path SHALL exist.
REQ-026 All outputs SHALL be driven from registers; no combinational input-to-output path.

Reset
REQ-027 rst asserted SHALL immediately (asynchronously) set data_out=SEED, active seed=SEED, step_count=0, period_len=0, period_done=0, lockup_err=0.
REQ-028 rst asserted mid-sequence or during load SHALL abort the operation; first step after release advances from SEED.
REQ-029 Reset initial value SHALL match the power-up register value.

Verification
REQ-030 Defaults, reset, en=1 for 3 cycles -> data_out 1, 2, 4, 9.
REQ-031 Defaults, en=1 held 127 cycles -> data_out returns to 1, period_done pulses once, period_len=127, step_count=0, no earlier repeat of state 1.
REQ-032 GALOIS=1, TAPS=7'b0001001, from 1, en=1 for 7 cycles -> 2, 4, 8, 16, 32, 64, 9.
REQ-033 load=1, seed_in=0 with en=1 -> data_out=SEED, lockup_err high one cycle, step_count=0, state unadvanced.
REQ-034 load=1, seed_in=7'h55, then 127 steps -> period_done pulse with data_out=7'h55, period_len=127.
REQ-035 rst pulsed between clock edges mid-run -> data_out=1 and counters 0 before next edge; en idle cycles hold all outputs.
